branch_ctrl: RTL
================

Name: branch_ctrl

Overview:
- ID-stage branch resolution controller for the five-stage MIPS pipeline.
- Owns the single branch comparator. Holds each branch in ID until both forwarded operands are ready, then fires one compare and resolves taken/not-taken.
- Produces the redirect target and a pipeline stall. Handles delay-slot annulment for branch-likely forms.
- Keeps saturating-free (wrapping) performance counters for branches, taken branches and branch stall cycles.

Parameters:
- CNT_W, 32, width of each performance counter (wraps modulo 2^CNT_W).
- MAX_WAIT, 15, operand-wait limit in cycles; exceeding it raises wait_err.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- br_valid  input  1  ID holds a branch instruction
- br_cmpop  input  5  comparison code (shared CMP_* constants: EQ/NE/LT/LE/GT/GE)
- br_likely  input  1  branch-likely form: annul the delay slot when not taken
- br_pc  input  32  PC of the branch
- br_imm  input  16  branch offset field
- rs_data  input  32  forwarded rs value
- rt_data  input  32  forwarded rt value
- rs_ready  input  1  rs value final (no pending producer)
- rt_ready  input  1  rt value final
- ext_stall  input  1  ID frozen by another unit (e.g. MDU busy)
- stall  output  1  branch-induced ID/IF stall
- resolve  output  1  branch resolved this cycle
- taken  output  1  resolved outcome (valid with resolve)
- target  output  32  br_pc+4+(sext(br_imm)<<2); valid with resolve&&taken
- annul_slot  output  1  flush the delay slot in IF/ID (one cycle)
- wait_err  output  1  sticky: operand wait exceeded MAX_WAIT
- cnt_branch  output  CNT_W  resolved branches
- cnt_taken  output  CNT_W  resolved taken branches
- cnt_stall  output  CNT_W  cycles with stall=1

Behaviour:
- Reset (async, any state): state=IDLE, wait_cnt=0, all counters=0, wait_err=0, annul_slot=0. Combinational outputs follow from the reset state and the current inputs.
- ready = rs_ready && rt_ready. go = br_valid && !ext_stall.
- stall = go && !ready (combinational). Branches never stall when operands are ready: the compare is same-cycle.
- resolve = go && ready && state!=SLOT (combinational).
- taken = resolve && cmp_out.
- target is computed every cycle. Offset arithmetic is 32-bit and wraps.
- States:
  - IDLE: if go&&!ready, go to WAIT and set wait_cnt=1. If resolve&&!taken&&br_likely, go to SLOT. Otherwise stay in IDLE.
  - WAIT: if go&&!ready, increment wait_cnt (saturates at MAX_WAIT+1). wait_err is set when wait_cnt reaches MAX_WAIT+1. On resolve, go to SLOT (likely, not taken) or IDLE, and clear wait_cnt. If br_valid drops (flush from a later stage), go to IDLE and clear wait_cnt.
  - SLOT: annul_slot=1 for exactly this one registered cycle, then go to IDLE. A branch in ID during SLOT is the annulled slot instruction and is not resolved and not counted.
- ext_stall=1 freezes the FSM and wait_cnt, and suppresses resolve and stall. Only the blocking unit stalls the pipe.
- Counters update on the clock edge:
  - cnt_branch +1 on resolve.
  - cnt_taken +1 on taken.
  - cnt_stall +1 on stall.
  - All three wrap at 2^CNT_W.
- Undefined br_cmpop: the comparator returns 0, so the branch resolves as not taken.
- Back-to-back branches are supported with no bubble (resolve on consecutive cycles).
- wait_err is cleared only by reset.

Decomposition:
- Shared defines file holds the CMP_* opcode constants and the state encodings IDLE/WAIT/SLOT. No new typedefs are needed.
- One sub-module: the existing comparator `CMP`, instantiated once with A=rs_data, B=rt_data, CMPOp=br_cmpop. cmp_out is taken from its Zero output.

Test Plan:
- beq, rs=rt=0x5, both ready, pc=0x3000, imm=0x0004 -> same cycle: resolve=1, taken=1, target=0x3014, stall=0; cnt_branch=1 and cnt_taken=1 after the edge.
- bne, rs_ready=0 for 2 cycles, then rs=1, rt=1 -> stall=1 for 2 cycles, then resolve=1, taken=0; cnt_stall=2.
- Branch-likely LT with rs=0x0000_0005, rt=0xFFFF_FFFF (signed compare) -> taken=0; annul_slot=1 on the next cycle only; a br_valid in that cycle is not resolved and cnt_branch stays at 1.
- ext_stall=1 for 3 cycles with a ready branch -> resolve=0 and stall=0 throughout; resolves on the first cycle ext_stall=0; counters unchanged until then.
- Operands unready for 16 cycles with MAX_WAIT=15 -> wait_err=1 and stays set after resolve; reset asserted in WAIT -> state=IDLE and counters=0 immediately.
- CNT_W=4, 17 consecutive taken branches with imm=0xFFFF -> target=pc, no bubbles, cnt_taken wraps to 1.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// rtl/branch_ctrl_pkg.sv - shared compare opcodes, FSM encodings and target helper for branch_ctrl
package branch_ctrl_pkg;

  // Comparator opcodes shared with the decoder (all magnitude compares are signed)
  localparam logic [4:0] CMP_EQ = 5'd0;
  localparam logic [4:0] CMP_NE = 5'd1;
  localparam logic [4:0] CMP_LT = 5'd2;
  localparam logic [4:0] CMP_LE = 5'd3;
  localparam logic [4:0] CMP_GT = 5'd4;
  localparam logic [4:0] CMP_GE = 5'd5;

  // Branch FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SLOT = 2'd2;

  // pc + 4 + (sext(imm) << 2), wrapping at 32 bits
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_ctrl_cmp.sv
// rtl/branch_ctrl_cmp.sv - single branch comparator, Zero=1 when the selected condition holds
module branch_ctrl_cmp
  import branch_ctrl_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  CMPOp,
  output logic        Zero
);

  // Evaluate the selected condition; unknown opcodes report false so the branch falls through
  always_comb begin
    Zero = 1'b0;
    case (CMPOp)
      CMP_EQ:  Zero = (A == B);
      CMP_NE:  Zero = (A != B);
      CMP_LT:  Zero = ($signed(A) <  $signed(B));
      CMP_LE:  Zero = ($signed(A) <= $signed(B));
      CMP_GT:  Zero = ($signed(A) >  $signed(B));
      CMP_GE:  Zero = ($signed(A) >= $signed(B));
      default: Zero = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - ID-stage branch resolution, stall, delay-slot annul and perf counters
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [4:0]       br_cmpop,
  input  logic             br_likely,
  input  logic [31:0]      br_pc,
  input  logic [15:0]      br_imm,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic             ext_stall,
  output logic             stall,
  output logic             resolve,
  output logic             taken,
  output logic [31:0]      target,
  output logic             annul_slot,
  output logic             wait_err,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_stall
);

  // Wait counter must hold MAX_WAIT+1, the value that flags the error
  localparam int                WCNT_W   = $clog2(MAX_WAIT + 2);
  localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(MAX_WAIT + 1);

  logic [1:0]        r_state;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_wait_err;
  logic [CNT_W-1:0]  r_cnt_branch;
  logic [CNT_W-1:0]  r_cnt_taken;
  logic [CNT_W-1:0]  r_cnt_stall;

  logic              w_ready;
  logic              w_go;
  logic              w_cmp_out;
  logic [1:0]        w_state_nxt;
  logic [WCNT_W-1:0] w_wait_nxt;

  branch_ctrl_cmp u_cmp (
    .A     (rs_data),
    .B     (rt_data),
    .CMPOp (br_cmpop),
    .Zero  (w_cmp_out)
  );

  assign w_ready    = rs_ready && rt_ready;
  assign w_go       = br_valid && !ext_stall;
  assign stall      = w_go && !w_ready;
  // The instruction in ID during SLOT is the annulled delay slot, never a real branch
  assign resolve    = w_go && w_ready && (r_state != ST_SLOT);
  assign taken      = resolve && w_cmp_out;
  assign target     = branch_target(br_pc, br_imm);
  assign annul_slot = (r_state == ST_SLOT);
  assign wait_err   = r_wait_err;
  assign cnt_branch = r_cnt_branch;
  assign cnt_taken  = r_cnt_taken;
  assign cnt_stall  = r_cnt_stall;

  // Next-state and wait-count logic; an external stall freezes both
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    if (!ext_stall) begin
      case (r_state)
        ST_IDLE: begin
          if (stall) begin
            w_state_nxt = ST_WAIT;
            w_wait_nxt  = WCNT_W'(1);
          end else if (resolve && !w_cmp_out && br_likely) begin
            w_state_nxt = ST_SLOT;
          end
        end
        ST_WAIT: begin
          if (!br_valid) begin
            w_state_nxt = ST_IDLE;
            w_wait_nxt  = '0;
          end else if (stall) begin
            if (r_wait_cnt != WAIT_LIM) begin
              w_wait_nxt = r_wait_cnt + WCNT_W'(1);
            end
          end else begin
            w_state_nxt = (!w_cmp_out && br_likely) ? ST_SLOT : ST_IDLE;
            w_wait_nxt  = '0;
          end
        end
        ST_SLOT: begin
          w_state_nxt = ST_IDLE;
          w_wait_nxt  = '0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_wait_nxt  = '0;
        end
      endcase
    end
  end

  // State, wait count and sticky wait error registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_wait_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_wait_nxt == WAIT_LIM) begin
        r_wait_err <= 1'b1;
      end
    end
  end

  // Wrapping performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_branch <= '0;
      r_cnt_taken  <= '0;
      r_cnt_stall  <= '0;
    end else begin
      if (resolve) r_cnt_branch <= r_cnt_branch + CNT_W'(1);
      if (taken)   r_cnt_taken  <= r_cnt_taken + CNT_W'(1);
      if (stall)   r_cnt_stall  <= r_cnt_stall + CNT_W'(1);
    end
  end

endmodule
